instr_fetch_unit: RTL

Single-issue instruction fetch stage sitting directly upstream of the decode/control stage. It holds the PC and issues one request at a time to instruction memory over a req/ack handshake. It presents the fetched word and PC+4 to decode through a valid/ready handshake. When decode consumes an instruction, the redirect inputs (branch, j/jal, jr) select the next PC.

---
 rtl/instr_fetch_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetch stage: holds the PC, fetches one word at a time over
// imem req/ack, and hands {instr, pc_plus4} to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             nrst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      pc_plus4,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch_taken,
  input  logic [15:0]      branch_imm,
  input  logic             jump,
  input  logic [25:0]      jump_idx,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  output logic [CNT_W-1:0] fetch_count
);

  // Handshake: a transfer to decode happens on a rising edge where instr_valid && instr_ready;
  // instr/pc_plus4 stay stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        accept;

  assign accept = (state == VALID) && instr_ready;
  assign br_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Redirect priority: jr > jump > branch > sequential; only consumed when accept is high.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = {jr_target[31:2], 2'b00};
    else if (jump)
      next_pc = {pc_plus4[31:28], jump_idx, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + br_off;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = VALID;
      VALID:   if (instr_ready) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      pc          <= {RESET_PC[31:2], 2'b00};
      instr       <= 32'd0;
      pc_plus4    <= 32'd0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      // Acks outside FETCH (e.g. a request abandoned by reset) are ignored here.
      if (state == FETCH && imem_ack) begin
        instr       <= imem_rdata;
        pc_plus4    <= pc + 32'd4;
        instr_valid <= 1'b1;
      end
      if (accept) begin
        instr_valid <= 1'b0;
        fetch_count <= fetch_count + CNT_W'(1);
        pc          <= next_pc;
      end
    end
  end

endmodule
